// File: rtl/y_mc_ctrl_if.sv
// y_mc_ctrl_if: memory handshake, datapath flags and control strobes for y_mc_ctrl
interface y_mc_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             imem_ack;
  logic [31:0]      ins;
  logic             dmem_ack;
  logic             zero;
  logic [XLEN-1:0]  branch_off;
  logic [XLEN-1:0]  jal_off;
  logic [XLEN-1:0]  pc;
  logic [31:0]      ir;
  logic             imem_req;
  logic             RegWrite;
  logic             ALUSrc;
  logic             MemRead;
  logic             MemWrite;
  logic             Mem2Reg;
  logic [2:0]       op;
  logic [CNT_W-1:0] retired;
  logic             halted;
  logic             illegal;
  modport master (
    output imem_ack, ins, dmem_ack, zero, branch_off, jal_off,
    input  pc, ir, imem_req, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, retired, halted, illegal
  );
  modport slave (
    input  imem_ack, ins, dmem_ack, zero, branch_off, jal_off,
    output pc, ir, imem_req, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, retired, halted, illegal
  );
endinterface

// File: rtl/y_mc_ctrl.sv
// y_mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer holding pc, ir and retired count
module y_mc_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 'h28,
  parameter int              CNT_W    = 16
) (
  input logic        clk,
  input logic        rst,
  y_mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LW = 7'h03, OP_SW = 7'h23;
  localparam logic [6:0] OP_BEQ = 7'h63, OP_JAL = 7'h6f, OP_ECALL = 7'h73;
  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d, tgt;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d, retire, legal;
  logic [9:0]       ctl_q, ctl_d;
  logic [6:0]       opc;
  logic [2:0]       f3;
  // ctl = {imem_req, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op[2:0], halted}
  function automatic logic [9:0] ctl_of(input state_t s, input logic [31:0] i);
    logic [6:0] o;
    logic       ex;
    logic [2:0] alu;
    o   = i[6:0];
    ex  = s == EXEC || s == MEM;
    alu = o == OP_BEQ ? 3'b110 : o != OP_R ? 3'b010 :
          i[14:12] == 3'b110 ? 3'b001 : i[14:12] == 3'b111 ? 3'b000 :
          i[30] ? 3'b110 : 3'b010;
    return {s == FETCH, s == WB, ex && o != OP_R && o != OP_BEQ,
            s == MEM && o == OP_LW, s == MEM && o == OP_SW, s == WB && o == OP_LW,
            ex ? alu : 3'b000, s == HALT};
  endfunction
  assign opc   = ir_q[6:0];
  assign f3    = ir_q[14:12];
  assign legal = opc == OP_I || opc == OP_LW || opc == OP_SW || opc == OP_BEQ || opc == OP_JAL ||
                 (opc == OP_R && (f3 == 3'b000 || f3 == 3'b110 || f3 == 3'b111));
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    tgt       = pc_q + XLEN'(4);
    case (state_q)
      FETCH: if (ctl_q[9] && bus.imem_ack) begin
        ir_d    = bus.ins;
        state_d = DECODE;
      end
      DECODE: begin
        state_d   = legal ? EXEC : HALT;
        illegal_d = illegal_q | (!legal && opc != OP_ECALL);
      end
      EXEC: begin
        state_d = opc == OP_LW || opc == OP_SW ? MEM : WB;
        retire  = opc == OP_BEQ || opc == OP_JAL;
        tgt     = opc == OP_JAL ? pc_q + bus.jal_off : bus.zero ? pc_q + bus.branch_off : tgt;
      end
      MEM: if (bus.dmem_ack) begin
        state_d = WB;
        retire  = opc == OP_SW;
      end
      WB:      retire = 1'b1;
      default: ;
    endcase
    // Every retirement passes through here so a misaligned target never reaches pc
    if (retire) begin
      state_d   = tgt[1:0] != 2'b00 ? HALT : FETCH;
      illegal_d = illegal_q | (tgt[1:0] != 2'b00);
      pc_d      = tgt[1:0] != 2'b00 ? pc_q : tgt;
      retired_d = tgt[1:0] != 2'b00 ? retired_q : retired_q + CNT_W'(1);
    end
    ctl_d = ctl_of(state_d, ir_d);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      ir_q      <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      ctl_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
      ctl_q     <= ctl_d;
    end
  end
  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.retired  = retired_q;
  assign bus.illegal  = illegal_q;
  assign bus.imem_req = ctl_q[9];
  assign bus.RegWrite = ctl_q[8];
  assign bus.ALUSrc   = ctl_q[7];
  assign bus.MemRead  = ctl_q[6];
  assign bus.MemWrite = ctl_q[5];
  assign bus.Mem2Reg  = ctl_q[4];
  assign bus.op       = ctl_q[3:1];
  assign bus.halted   = ctl_q[0];
endmodule

// File: tb/tb_y_mc_ctrl.sv
// tb_y_mc_ctrl: directed instruction sequences with hand-computed strobes, pc and retired count
module tb_y_mc_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errs = 0;
  int   checks = 0;
  // {imem_req, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg, op, halted}
  localparam logic [9:0] C_IDLE = 10'b0_0_0_0_0_0_000_0, C_FETCH = 10'b1_0_0_0_0_0_000_0;
  localparam logic [9:0] C_ADDEX = 10'b0_0_0_0_0_0_010_0, C_WB = 10'b0_1_0_0_0_0_000_0;
  localparam logic [9:0] C_IMMEX = 10'b0_0_1_0_0_0_010_0, C_LWMEM = 10'b0_0_1_1_0_0_010_0;
  localparam logic [9:0] C_LWWB = 10'b0_1_0_0_0_1_000_0, C_SWMEM = 10'b0_0_1_0_1_0_010_0;
  localparam logic [9:0] C_BEQEX = 10'b0_0_0_0_0_0_110_0, C_HALT = 10'b0_0_0_0_0_0_000_1;
  localparam logic [31:0] I_ADD = 32'h002081B3, I_LW = 32'h0000A183, I_SW = 32'h0020A023;
  localparam logic [31:0] I_BEQ = 32'h00208463, I_JAL = 32'h0000006F, I_ECALL = 32'h00000073;
  logic [31:0] r_ins [4] = '{32'h402081B3, 32'h0020E1B3, 32'h0020F1B3, 32'h00108193};
  logic [9:0]  r_ex  [4] = '{10'b0_0_0_0_0_0_110_0, 10'b0_0_0_0_0_0_001_0,
                             10'b0_0_0_0_0_0_000_0, 10'b0_0_1_0_0_0_010_0};
  y_mc_ctrl_if #(.XLEN(32), .CNT_W(16)) bus();
  y_mc_ctrl #(.XLEN(32), .PC_RESET(32'h28), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [9:0] ctl();
    return {bus.imem_req, bus.RegWrite, bus.ALUSrc, bus.MemRead, bus.MemWrite, bus.Mem2Reg, bus.op, bus.halted};
  endfunction
  task automatic go(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic restart();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    go(1);
    rst = 1'b0;
    go(1);
  endtask
  task automatic fetch(input logic [31:0] i);
    bus.ins = i;
    bus.imem_ack = 1'b1;
    go(1);
    bus.imem_ack = 1'b0;
  endtask
  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.ins = '0;
    bus.zero = 1'b0;
    bus.branch_off = '0;
    bus.jal_off = '0;
    #1 rst = 1'b1;
    go(3);
    chk("rst_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("rst_pc", bus.pc, 32'h28);
    chk("rst_ir", bus.ir, 32'h0);
    chk("rst_ret", 32'(bus.retired), 32'd0);
    chk("rst_ill", 32'(bus.illegal), 32'd0);
    rst = 1'b0;
    go(1);
    chk("first_req", 32'(ctl()), 32'(C_FETCH));
    // add with a stray dmem_ack held high throughout
    bus.dmem_ack = 1'b1;
    fetch(I_ADD);
    chk("add_dec", 32'(ctl()), 32'(C_IDLE));
    chk("add_ir", bus.ir, I_ADD);
    go(1);
    chk("add_ex", 32'(ctl()), 32'(C_ADDEX));
    go(1);
    chk("add_wb", 32'(ctl()), 32'(C_WB));
    go(1);
    chk("add_fetch", 32'(ctl()), 32'(C_FETCH));
    chk("add_pc", bus.pc, 32'h2C);
    chk("add_ret", 32'(bus.retired), 32'd1);
    // sw, zero wait
    fetch(I_SW);
    go(1);
    chk("sw_ex", 32'(ctl()), 32'(C_IMMEX));
    go(1);
    chk("sw_mem", 32'(ctl()), 32'(C_SWMEM));
    go(1);
    bus.dmem_ack = 1'b0;
    chk("sw_pc", bus.pc, 32'h30);
    chk("sw_ret", 32'(bus.retired), 32'd2);
    // ALU op decode: sub, or, and, addi
    for (int k = 0; k < 4; k++) begin
      fetch(r_ins[k]);
      go(1);
      chk($sformatf("rop_ex%0d", k), 32'(ctl()), 32'(r_ex[k]));
      go(1);
      chk($sformatf("rop_wb%0d", k), 32'(ctl()), 32'(C_WB));
      go(1);
    end
    chk("rop_pc", bus.pc, 32'h40);
    chk("rop_ret", 32'(bus.retired), 32'd6);
    // backward jal to 0x28
    bus.jal_off = 32'hFFFF_FFE8;
    fetch(I_JAL);
    go(1);
    chk("jal_ex", 32'(ctl()), 32'(C_IMMEX));
    go(1);
    chk("jal_pc", bus.pc, 32'h28);
    chk("jal_ret", 32'(bus.retired), 32'd7);
    // lw with dmem_ack two cycles late
    fetch(I_LW);
    go(1);
    chk("lw_ex", 32'(ctl()), 32'(C_IMMEX));
    for (int k = 0; k < 3; k++) begin
      go(1);
      chk($sformatf("lw_mem%0d", k), 32'(ctl()), 32'(C_LWMEM));
    end
    bus.dmem_ack = 1'b1;
    go(1);
    bus.dmem_ack = 1'b0;
    chk("lw_wb", 32'(ctl()), 32'(C_LWWB));
    go(1);
    chk("lw_pc", bus.pc, 32'h2C);
    chk("lw_ret", 32'(bus.retired), 32'd8);
    // beq not taken then taken
    bus.branch_off = 32'd8;
    bus.zero = 1'b0;
    fetch(I_BEQ);
    go(1);
    chk("beq0_ex", 32'(ctl()), 32'(C_BEQEX));
    go(1);
    chk("beq0_pc", bus.pc, 32'h30);
    bus.zero = 1'b1;
    fetch(I_BEQ);
    go(2);
    chk("beq1_pc", bus.pc, 32'h38);
    chk("beq1_ret", 32'(bus.retired), 32'd10);
    // reset in the middle of a sw MEM wait
    fetch(I_SW);
    go(2);
    chk("swr_mem0", 32'(ctl()), 32'(C_SWMEM));
    go(1);
    chk("swr_mem1", 32'(ctl()), 32'(C_SWMEM));
    #2 rst = 1'b1;
    #1;
    chk("swr_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("swr_pc", bus.pc, 32'h28);
    chk("swr_ret", 32'(bus.retired), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    go(1);
    chk("swr_fetch", 32'(ctl()), 32'(C_FETCH));
    // illegal opcode, then stray acks while halted
    fetch(32'h0000007F);
    go(1);
    chk("ill_ctl", 32'(ctl()), 32'(C_HALT));
    chk("ill_flag", 32'(bus.illegal), 32'd1);
    chk("ill_pc", bus.pc, 32'h28);
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    go(3);
    chk("ill_stay", 32'(ctl()), 32'(C_HALT));
    restart();
    chk("ill_clr", 32'(bus.illegal), 32'd0);
    chk("ill_refetch", 32'(ctl()), 32'(C_FETCH));
    // R-type with unsupported funct3
    fetch(32'h002091B3);
    go(1);
    chk("f3_ctl", 32'(ctl()), 32'(C_HALT));
    chk("f3_flag", 32'(bus.illegal), 32'd1);
    // misaligned jal target
    restart();
    bus.jal_off = 32'd2;
    fetch(I_JAL);
    go(2);
    chk("mis_ctl", 32'(ctl()), 32'(C_HALT));
    chk("mis_flag", 32'(bus.illegal), 32'd1);
    chk("mis_pc", bus.pc, 32'h28);
    chk("mis_ret", 32'(bus.retired), 32'd0);
    // ecall after two FETCH wait cycles
    restart();
    go(2);
    chk("wait_req", 32'(ctl()), 32'(C_FETCH));
    fetch(I_ECALL);
    chk("ecall_dec", 32'(ctl()), 32'(C_IDLE));
    go(1);
    chk("ecall_ctl", 32'(ctl()), 32'(C_HALT));
    chk("ecall_flag", 32'(bus.illegal), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/y_mc_ctrl.md
# y_mc_ctrl

Multi-cycle control unit and PC sequencer for the RISC-V datapath (yIF/yID/yEX/yDM/yWB). It moves instruction decode and control generation out of the bench into RTL. It holds the PC and an instruction register, and it sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Memory uses req/ack handshakes with arbitrary wait states, and the unit halts on ecall, an illegal opcode or a misaligned target.

## Interface
- XLEN, 32: PC/offset width.
- PC_RESET, 32'h28: PC value loaded on reset.
- CNT_W, 16: width of retired-instruction counter.
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_ack  in  1  instruction memory ack; `ins` valid when high.
- ins  in  32  fetched instruction.
- dmem_ack  in  1  data memory ack; completes MEM state.
- zero  in  1  ALU zero flag from yEX.
- branch_off  in  XLEN  sign-extended B-type byte offset from yID.
- jal_off  in  XLEN  sign-extended J-type byte offset from yID.
- pc  out  XLEN  current PC, drives yIF.
- ir  out  32  latched instruction, drives yID.
- imem_req, RegWrite, ALUSrc, MemRead, MemWrite, Mem2Reg  out  1  control strobes.
- op  out  3  ALU operation to yEX.
- retired  out  CNT_W  completed-instruction count, wraps modulo 2^CNT_W.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; high if HALT was entered through a fault.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- All outputs are Moore outputs, decoded from the state register and `ir`. There is no combinational path from input to output.
- FETCH:
  - imem_req=1.
  - On a cycle with imem_ack=1, latch ins into ir and go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: decode ir[6:0] and go to EXEC, except as follows.
  - 0x73 (ecall): go to HALT with illegal=0.
  - Any opcode other than 0x33, 0x13, 0x03, 0x23, 0x63, 0x6F: go to HALT with illegal=1.
- EXEC: ALUSrc=0 for 0x33 and 0x63; ALUSrc=1 otherwise.
- op by instruction type:
  - 0x33 funct3=000, funct7[5]=0 (add): 010.
  - 0x33 funct3=000, funct7[5]=1 (sub): 110.
  - 0x33 funct3=110 (or): 001.
  - 0x33 funct3=111 (and): 000.
  - 0x63 (beq): 110.
  - All others: 010.
  - Any other 0x33 funct3 is illegal and is caught in DECODE.
- EXEC exit:
  - 0x33 and 0x13: go to WB.
  - 0x03 and 0x23: go to MEM.
  - 0x63: target = pc + branch_off if zero=1, else pc + 4. Go to FETCH.
  - 0x6F: target = pc + jal_off. Go to FETCH. No link write.
- MEM: keep EXEC's ALUSrc/op so the address stays stable.
  - lw: MemRead=1 until dmem_ack, then go to WB.
  - sw: MemWrite=1 until dmem_ack, then pc += 4 and go to FETCH.
- WB: RegWrite=1 for exactly one cycle; Mem2Reg=1 only for lw. Then pc += 4 and go to FETCH.
- Retirement: every PC update is a retirement and increments `retired` in the same cycle.
- PC arithmetic: modulo 2^XLEN.
- Misaligned target (target[1:0]≠0):
  - pc is not updated and `retired` is not incremented.
  - Go to HALT and set illegal=1.
- HALT: all strobes 0, halted=1. Only rst leaves HALT.

## Timing
- Reset (asserted asynchronously, held any time):
  - state=FETCH, pc=PC_RESET, ir=0, retired=0, illegal=0.
  - All strobes 0, including imem_req.
- First rising edge after deassertion: imem_req=1.
- Zero-wait latency in cycles:
  - R-type/addi: 4 (F, D, E, W).
  - lw: 5.
  - sw: 4.
  - beq/jal: 3.
  - ecall: 2 to HALT.
- Each wait cycle (ack low) extends FETCH or MEM by 1.
- Handshake: ack is sampled only in the matching state. Stray acks in other states are ignored.
- A req stays high until its ack is sampled. Control outputs are stable throughout MEM.
- Reset mid-MEM or mid-FETCH: all strobes drop immediately (async), with no retirement and no PC change other than the reset value.
- `retired` wrap: 2^CNT_W-1 → 0 with no flag.

## Test plan
- Reset then idle: rst high for 3 cycles, then low.
  - During reset: pc=0x28 and all strobes 0.
  - Next cycle: imem_req=1.
- add x3,x1,x2 (0x002081B3), ack always high:
  - DECODE at cycle 2, EXEC op=010 ALUSrc=0 at cycle 3.
  - WB RegWrite=1 Mem2Reg=0 for 1 cycle.
  - Then pc=0x2C, retired=1.
- lw (0x0000A183) with dmem_ack delayed 2 cycles:
  - MemRead high for 3 cycles, then WB with Mem2Reg=1 and RegWrite=1.
  - Total latency 7 cycles, pc=0x2C.
- beq (0x00208463):
  - branch_off=8, zero=1 → pc=0x30 after 3 cycles.
  - Repeat with zero=0 → pc=0x2C.
- Faults, from pc=0x28:
  - Opcode 0x7F → halted=1, illegal=1, pc=0x28.
  - jal with jal_off=2 → halted=1, illegal=1, pc=0x28, retired unchanged.
  - ecall → halted=1, illegal=0.
- Reset during sw MEM wait: MemWrite falls in the same cycle as rst, pc=0x28, retired=0.
